pclk_lock_detect: RTL
=====================

// Module: pclk_lock_detect
// PURPOSE
//  Frequency-lock monitor for the PLL divided clock. Sits directly downstream of the
//  clock divider, on the Ref_Clk domain. Measures each pclk period in Ref_Clk cycles,
//  compares it against the programmed div_ratio, and asserts locked once the period
//  has been stable. Flags period errors and a stalled pclk.
// PARAMETERS
//  LOCK_CNT    4  consecutive good periods required to assert locked (1..15)
//  UNLOCK_CNT  2  consecutive bad periods/timeouts required to drop locked (1..15)
//  TOL         1  allowed |measured - div_ratio| in Ref_Clk cycles
// PORTS
//  Ref_Clk      in   1  reference clock; the only clock
//  rst          in   1  synchronous reset, active-low
//  div_ratio    in   8  expected pclk period in Ref_Clk cycles; valid range 2..255
//  pclk         in   1  divided clock under test, sampled as data
//  locked       out  1  pclk period matches div_ratio (level)
//  meas_period  out  9  last completed period measurement (saturates at 511)
//  lock_err     out  1  one-cycle pulse per bad period or timeout
// BEHAVIOUR
//  - Reset (rst==0 at a Ref_Clk edge): state=IDLE; locked=0; meas_period=0; lock_err=0;
//    sync flops, counters and the good/bad counts cleared. Reset mid-operation aborts
//    immediately, with no lock_err.
//  - pclk passes through a 2-flop synchronizer, then a rising-edge detector.
//    edge_pulse is high 3 Ref_Clk cycles after pclk rises. This fixed offset cancels in
//    the period measurement.
//  - Period counter (9b): increments every cycle and saturates at 511. On edge_pulse,
//    count+1 is loaded into meas_period and the counter restarts from 0. The first edge
//    after entering ACQUIRE only arms the counter and is not evaluated.
//  - Good period: |meas - div_ratio| <= TOL (compared in 10b signed math). Bad period:
//    any other value.
//  - Timeout: the counter reaches 2*div_ratio with no edge. This counts as one bad
//    period. The counter restarts and meas_period is unchanged.
//  - div_ratio is registered every cycle. A change (reg != input) forces ACQUIRE, with
//    counts cleared and locked=0 on the next cycle. No lock_err is raised.
//  - FSM:
//    IDLE    -> ACQUIRE when div_ratio >= 2. Ratio 0/1 holds IDLE and locked=0.
//    ACQUIRE: good period -> good_cnt++. Bad period -> good_cnt=0 and lock_err pulse.
//             good_cnt==LOCK_CNT -> LOCKED; locked=1 registered the same cycle the
//             count is reached.
//    LOCKED:  good period -> bad_cnt=0. Bad period or timeout -> bad_cnt++ and
//             lock_err pulse. bad_cnt==UNLOCK_CNT -> ACQUIRE, locked=0, counts cleared.
//    Any state -> IDLE if div_ratio < 2.
//  - When an edge and a timeout occur in the same cycle, the edge wins (measured as
//    2*div_ratio).
//  - lock_err is never asserted in IDLE or in the cycle after reset release.
// TESTING
//  1 ratio=20, clean pclk period 20 -> meas_period=20; locked rises on the 5th pclk
//    edge after ACQUIRE (arm + 4 good); lock_err never pulses.
//  2 ratio=20, pclk period 22 (TOL=1) -> locked stays 0; lock_err pulses once per
//    period; meas_period=22.
//  3 locked at ratio=20, then pclk held low -> lock_err at 40 and 80 cycles after the
//    last edge; locked falls with the second timeout.
//  4 locked at ratio=20, then div_ratio set to 10 with pclk retimed to 10 -> locked
//    drops the next cycle, no lock_err, relock after arm + 4 edges; meas_period=10.
//  5 rst pulsed low for 1 cycle while LOCKED -> all outputs 0 the next cycle;
//    reacquires normally.
//  6 ratio=1 or 0 with pclk toggling -> stays IDLE; locked=0; lock_err=0 throughout.

Source files
------------

// File: rtl/pclk_lock_detect.sv
// rtl/pclk_lock_detect.sv - PLL divided-clock frequency lock monitor on the Ref_Clk domain
// Measures each pclk period in Ref_Clk cycles and tracks lock against div_ratio.

module pclk_lock_detect #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int TOL        = 1
) (
  input  logic       Ref_Clk,
  input  logic       rst,
  input  logic [7:0] div_ratio,
  input  logic       pclk,
  output logic       locked,
  output logic [8:0] meas_period,
  output logic       lock_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0]        LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0]        UNLOCK_N = 4'(UNLOCK_CNT);
  localparam logic signed [9:0] TOL_S    = 10'(TOL);

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        sync3_q, sync3_d;
  logic        edge_q, edge_d;
  logic [7:0]  ratio_q, ratio_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  meas_q, meas_d;
  logic        armed_q, armed_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [3:0]  bad_cnt_q, bad_cnt_d;
  logic        locked_q, locked_d;
  logic        lock_err_q, lock_err_d;

  logic [9:0]        cnt_p1;
  logic [8:0]        meas_val;
  logic signed [9:0] diff;
  logic              good;
  logic              timeout;

  always_comb begin
    sync1_d = pclk;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    edge_d  = sync2_q & ~sync3_q;
    ratio_d = div_ratio;

    // cnt_p1 is the length of the period that would end on this cycle
    cnt_p1   = {1'b0, cnt_q} + 10'd1;
    meas_val = cnt_p1[9] ? 9'd511 : cnt_p1[8:0];
    diff     = $signed({1'b0, meas_val}) - $signed({2'b00, ratio_q});
    good     = (diff >= -TOL_S) && (diff <= TOL_S);
    timeout  = armed_q && !edge_q && (cnt_p1 == {1'b0, ratio_q, 1'b0});
    cnt_d    = (edge_q || timeout) ? 9'd0 : meas_val;

    state_d    = state_q;
    armed_d    = armed_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    locked_d   = locked_q;
    meas_d     = meas_q;
    lock_err_d = 1'b0;

    if (ratio_q != div_ratio) begin
      state_d    = (div_ratio >= 8'd2) ? ST_ACQUIRE : ST_IDLE;
      armed_d    = 1'b0;
      good_cnt_d = 4'd0;
      bad_cnt_d  = 4'd0;
      locked_d   = 1'b0;
    end else if (ratio_q < 8'd2) begin
      state_d    = ST_IDLE;
      armed_d    = 1'b0;
      good_cnt_d = 4'd0;
      bad_cnt_d  = 4'd0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (edge_q && !armed_q) begin
            armed_d = 1'b1;
          end else if (edge_q && good) begin
            meas_d = meas_val;
            if (good_cnt_q + 4'd1 == LOCK_N) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              good_cnt_d = 4'd0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else if (edge_q || timeout) begin
            if (edge_q) meas_d = meas_val;
            good_cnt_d = 4'd0;
            lock_err_d = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (edge_q && good) begin
            meas_d    = meas_val;
            bad_cnt_d = 4'd0;
          end else if (edge_q || timeout) begin
            if (edge_q) meas_d = meas_val;
            lock_err_d = 1'b1;
            // Dropping lock re-enters acquisition, so the next edge only re-arms
            if (bad_cnt_q + 4'd1 == UNLOCK_N) begin
              state_d    = ST_ACQUIRE;
              locked_d   = 1'b0;
              armed_d    = 1'b0;
              good_cnt_d = 4'd0;
              bad_cnt_d  = 4'd0;
            end else begin
              bad_cnt_d = bad_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Ref_Clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      edge_q     <= 1'b0;
      ratio_q    <= 8'd0;
      cnt_q      <= 9'd0;
      meas_q     <= 9'd0;
      armed_q    <= 1'b0;
      good_cnt_q <= 4'd0;
      bad_cnt_q  <= 4'd0;
      locked_q   <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      edge_q     <= edge_d;
      ratio_q    <= ratio_d;
      cnt_q      <= cnt_d;
      meas_q     <= meas_d;
      armed_q    <= armed_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign locked      = locked_q;
  assign meas_period = meas_q;
  assign lock_err    = lock_err_q;

endmodule
